// File: rtl/seq_detector_param_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Supports pattern widths up to MASK_MAX bits.
package seq_det_pkg;

    localparam int unsigned MASK_MAX = 64;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Low 'len' bits set; callers compare at MASK_MAX width so no bits go unused.
    function automatic logic [MASK_MAX-1:0] len2mask(input int unsigned len);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter: increment enable, synchronous clear, holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered detect pulse and saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int unsigned PAT_W = 8,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             data,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             clear,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    logic [PAT_W-1:0]    hist;
    logic [PAT_W-1:0]    h_nxt;
    logic [LEN_W-1:0]    fill;
    logic [LEN_W-1:0]    f_nxt;
    logic [MASK_MAX-1:0] diff;
    logic                cfg_bad;
    logic                hit;
    logic                beat;
    ovl_mode_e           mode;

    always_comb begin
        mode    = ovl_mode_e'(overlap_en);
        beat    = in_valid && !clear;
        h_nxt   = {hist[PAT_W-2:0], data};
        f_nxt   = (fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill + LEN_W'(1);
        cfg_bad = (pat_len == '0) || (pat_len > LEN_W'(PAT_W));
        diff    = (MASK_MAX'(h_nxt) ^ MASK_MAX'(pattern)) & len2mask(32'(pat_len));
        hit     = !cfg_bad && (f_nxt >= pat_len) && (diff == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            detect  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_bad;
            detect  <= 1'b0;
            if (clear) begin
                hist <= '0;
                fill <= '0;
            end else if (in_valid) begin
                hist   <= h_nxt;
                // Non-overlapping mode restarts the fill so the next match needs fresh bits.
                fill   <= (hit && (mode == OVL_OFF)) ? '0 : f_nxt;
                detect <= hit;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (beat && hit),
        .clr (clear),
        .cnt (match_cnt)
    );

endmodule
